// File: rtl/addsub_sequencer.sv
// Sequencer driving an external 4-bit adder-subtracter.
// Performs ADD, SUB, CLR in one step and MUL by repeated addition.
module addsub_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    output logic [3:0] as_a,
    output logic [3:0] as_b,
    output logic       as_sub,
    input  logic [3:0] as_s,
    input  logic       as_carry,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       carry_out,
    output logic       zero,
    output logic       ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_opa;
    logic [3:0] r_opb;
    logic [1:0] r_opc;
    logic [3:0] r_acc;
    logic [3:0] r_count;
    logic       r_ovf_int;
    logic [3:0] r_result;
    logic       r_carry;
    logic       r_zero;
    logic       r_ovf;
    logic       w_mul_last;

    assign w_mul_last = (r_count == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        as_a   = 4'd0;
        as_b   = 4'd0;
        as_sub = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_EXEC;
            end
            S_EXEC: begin
                if (r_opc == OP_MUL) begin
                    as_a = r_acc;
                    as_b = r_opa;
                    if (w_mul_last) w_next = S_DONE;
                end else begin
                    as_a   = r_opa;
                    as_b   = r_opb;
                    as_sub = r_opc[0];
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa     <= 4'd0;
            r_opb     <= 4'd0;
            r_opc     <= 2'd0;
            r_acc     <= 4'd0;
            r_count   <= 4'd0;
            r_ovf_int <= 1'b0;
            r_result  <= 4'd0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b1;
            r_ovf     <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_opa     <= a_in;
                r_opb     <= b_in;
                r_opc     <= op;
                r_acc     <= 4'd0;
                r_count   <= b_in;
                r_ovf_int <= 1'b0;
            end
        end else if (r_state == S_EXEC) begin
            unique case (r_opc)
                OP_ADD, OP_SUB: begin
                    r_result <= as_s;
                    r_carry  <= as_carry;
                    r_ovf    <= 1'b0;
                    r_zero   <= (as_s == 4'd0);
                end
                OP_MUL: begin
                    if (w_mul_last) begin
                        r_result <= r_acc;
                        r_ovf    <= r_ovf_int;
                        r_carry  <= 1'b0;
                        r_zero   <= (r_acc == 4'd0);
                    end else begin
                        r_acc     <= as_s;
                        r_count   <= r_count - 4'd1;
                        r_ovf_int <= r_ovf_int | as_carry;
                    end
                end
                OP_CLR: begin
                    r_result <= 4'd0;
                    r_carry  <= 1'b0;
                    r_ovf    <= 1'b0;
                    r_zero   <= 1'b1;
                end
                default: begin
                    r_result <= r_result;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign carry_out = r_carry;
    assign zero      = r_zero;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed bench for addsub_sequencer with a behavioural
// 4-bit adder-subtracter closing the loop.
module tb_addsub_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [3:0] as_a;
    logic [3:0] as_b;
    logic       as_sub;
    logic [3:0] as_s;
    logic       as_carry;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       carry_out;
    logic       zero;
    logic       ovf;

    int n_vec = 0;
    int n_err = 0;

    addsub_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .as_a      (as_a),
        .as_b      (as_b),
        .as_sub    (as_sub),
        .as_s      (as_s),
        .as_carry  (as_carry),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // a + ~b + 1 for subtract, so carry=1 means no borrow
    logic [4:0] w_sum;
    assign w_sum    = {1'b0, as_a} + {1'b0, (as_sub ? ~as_b : as_b)}
                    + {4'd0, as_sub};
    assign as_s     = w_sum[3:0];
    assign as_carry = w_sum[4];

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o,
                       input logic [3:0] a, input logic [3:0] b,
                       input int e_res, input int e_cy,
                       input int e_z, input int e_ovf,
                       input int e_lat);
        int lat;
        @(negedge clk);
        op = o; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        if (o == 2'b00 || o == 2'b01) begin
            chk({tag, ".as_a"}, as_a, a);
            chk({tag, ".as_b"}, as_b, b);
            chk({tag, ".as_sub"}, as_sub, o[0]);
        end
        while (!done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, ".lat"}, lat, e_lat);
        chk({tag, ".res"}, result, e_res);
        chk({tag, ".cy"}, carry_out, e_cy);
        chk({tag, ".z"}, zero, e_z);
        chk({tag, ".ovf"}, ovf, e_ovf);
        @(posedge clk);
        #1;
        chk({tag, ".done_lo"}, done, 0);
        chk({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; op = 2'b00; a_in = 4'd0; b_in = 4'd0;
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.res", result, 0);
        chk("rst.z", zero, 1);
        chk("rst.as_a", as_a, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        run("add1", 2'b00, 4'd1, 4'd2, 3, 0, 0, 0, 2);
        run("sub1", 2'b01, 4'd3, 4'd1, 2, 1, 0, 0, 2);
        run("sub2", 2'b01, 4'd1, 4'd3, 14, 0, 0, 0, 2);
        run("add2", 2'b00, 4'd10, 4'd5, 15, 0, 0, 0, 2);
        run("add3", 2'b00, 4'd15, 4'd1, 0, 1, 1, 0, 2);
        run("mul1", 2'b10, 4'd3, 4'd5, 15, 0, 0, 0, 7);
        run("mul2", 2'b10, 4'd5, 4'd4, 4, 0, 0, 1, 6);
        run("add4", 2'b00, 4'd2, 4'd2, 4, 0, 0, 0, 2);
        run("mul0", 2'b10, 4'd7, 4'd0, 0, 0, 1, 0, 2);
        run("mulA0", 2'b10, 4'd0, 4'd3, 0, 0, 1, 0, 5);
        run("add5", 2'b00, 4'd6, 4'd1, 7, 0, 0, 0, 2);
        run("clr", 2'b11, 4'd9, 4'd9, 0, 0, 1, 0, 2);

        // start pulse mid-MUL must not disturb the running op
        @(negedge clk);
        op = 2'b10; a_in = 4'd3; b_in = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op = 2'b00; a_in = 4'd1; b_in = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("ign.res", result, 15);
            end
        end
        chk("ign.ndone", ndone, 1);
        chk("ign.as_b", as_b, 0);

        // async reset mid-MUL
        @(negedge clk);
        op = 2'b10; a_in = 4'd5; b_in = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.busy", busy, 0);
        chk("arst.done", done, 0);
        chk("arst.res", result, 0);
        chk("arst.z", zero, 1);
        chk("arst.as_a", as_a, 0);
        ndone = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("arst.ndone", ndone, 0);
        run("add6", 2'b00, 4'd1, 4'd1, 2, 0, 0, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
